// File: rtl/branch_predictor_seq.sv
// Two-state branch predictor: a 2-bit saturating counter per PC index predicts
// one in-flight conditional jump and flushes to the corrected address on a miss.
module branch_predictor_seq #(
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [21:0] I,
    input  logic [10:0] PC,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    output logic        predict_valid,
    output logic        predict_taken,
    output logic [10:0] next,
    output logic        busy,
    output logic        stall,
    output logic        flush,
    output logic [10:0] restore_pc
);

    // state     | meaning
    // S_IDLE    | no branch in flight, enable is accepted
    // S_PENDING | prediction issued, waiting for resolve_valid
    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    localparam int DEPTH = 1 << IDX_W;

    state_t             r_state;
    logic [1:0]         r_table [DEPTH];
    logic [IDX_W-1:0]   r_idx;
    logic [10:0]        r_target;
    logic [10:0]        r_fall;
    logic               r_dir;

    logic [IDX_W-1:0]   w_idx;
    logic [10:0]        w_fall;
    logic               w_dir;
    logic [1:0]         w_cnt_cur;
    logic [1:0]         w_cnt_nxt;
    logic               w_unused;

    assign w_idx     = PC[IDX_W-1:0];
    assign w_fall    = PC + 11'd1;
    assign w_dir     = r_table[w_idx][1];
    assign w_cnt_cur = r_table[r_idx];
    assign w_unused  = ^I[21:11];

    assign busy  = (r_state == S_PENDING);
    assign stall = enable && busy;

    always_comb begin
        w_cnt_nxt = w_cnt_cur;
        if (resolve_taken) begin
            if (w_cnt_cur != 2'b11) w_cnt_nxt = w_cnt_cur + 2'b01;
        end else begin
            if (w_cnt_cur != 2'b00) w_cnt_nxt = w_cnt_cur - 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_target      <= '0;
            r_fall        <= '0;
            r_dir         <= 1'b0;
            predict_valid <= 1'b0;
            predict_taken <= 1'b0;
            next          <= '0;
            flush         <= 1'b0;
            restore_pc    <= '0;
            for (int k = 0; k < DEPTH; k++) r_table[k] <= CNT_INIT;
        end else begin
            predict_valid <= 1'b0;
            flush         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_idx         <= w_idx;
                        r_target      <= I[10:0];
                        r_fall        <= w_fall;
                        r_dir         <= w_dir;
                        predict_valid <= 1'b1;
                        predict_taken <= w_dir;
                        next          <= w_dir ? I[10:0] : w_fall;
                        r_state       <= S_PENDING;
                    end
                end
                S_PENDING: begin
                    if (resolve_valid) begin
                        r_table[r_idx] <= w_cnt_nxt;
                        if (resolve_taken != r_dir) begin
                            flush      <= 1'b1;
                            restore_pc <= resolve_taken ? r_target : r_fall;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_predictor_seq.sv
// Self-checking bench for branch_predictor_seq: directed corner cases plus
// randomized branches checked against an array-of-counters reference model.
module tb_branch_predictor_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [21:0] I;
    logic [10:0] PC;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        predict_valid;
    logic        predict_taken;
    logic [10:0] next;
    logic        busy;
    logic        stall;
    logic        flush;
    logic [10:0] restore_pc;

    int total = 0;
    int bad   = 0;

    int          m_cnt [16];
    logic [10:0] m_rp_last;

    branch_predictor_seq #(.IDX_W(4), .CNT_INIT(2'b01)) dut (
        .clk(clk), .reset(reset), .enable(enable), .I(I), .PC(PC),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .predict_valid(predict_valid), .predict_taken(predict_taken),
        .next(next), .busy(busy), .stall(stall), .flush(flush),
        .restore_pc(restore_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [10:0] pc, input logic [10:0] tgt);
        enable = 1'b1;
        PC     = pc;
        I      = {11'($urandom), tgt};
        tick();
        enable = 1'b0;
    endtask

    task automatic resolve(input logic tk);
        resolve_valid = 1'b1;
        resolve_taken = tk;
        tick();
        resolve_valid = 1'b0;
    endtask

    function automatic logic m_dir(input logic [10:0] pc);
        return m_cnt[pc % 16] >= 2;
    endfunction

    task automatic m_update(input logic [10:0] pc, input logic tk);
        int i;
        i = pc % 16;
        if (tk) m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
        else    m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_cnt[i] = 1;
        m_rp_last = 11'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; PC = 11'h005; I = 22'h100;
        resolve_valid = 1'b0; resolve_taken = 1'b0;
        m_reset();
        #12;
        total++; if (predict_valid !== 1'b0) begin bad++; $display("FAIL reset_pv: got %b expected 0", predict_valid); end
        total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL reset_pt: got %b expected 0", predict_taken); end
        total++; if (next !== 11'h000) begin bad++; $display("FAIL reset_next: got %h expected 000", next); end
        total++; if (flush !== 1'b0 || restore_pc !== 11'h000) begin bad++; $display("FAIL reset_flush: got flush=%b rp=%h expected 0/000", flush, restore_pc); end
        total++; if (busy !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL reset_busy_stall: got busy=%b stall=%b expected 0/0", busy, stall); end
        enable = 1'b0;
        #2 reset = 1'b0;
        tick();
        total++; if (busy !== 1'b0 || predict_valid !== 1'b0) begin bad++; $display("FAIL post_reset_idle: got busy=%b pv=%b expected 0/0", busy, predict_valid); end
    endtask

    task automatic test_counter_training();
        issue(11'h005, 11'h100);
        total++; if ({predict_valid, predict_taken, next, busy} !== {1'b1, 1'b0, 11'h006, 1'b1}) begin bad++; $display("FAIL first_predict: got pv=%b pt=%b next=%h busy=%b expected 1/0/006/1", predict_valid, predict_taken, next, busy); end
        resolve(1'b1); m_update(11'h005, 1'b1); m_rp_last = 11'h100;
        total++; if ({flush, restore_pc, busy, predict_valid} !== {1'b1, 11'h100, 1'b0, 1'b0}) begin bad++; $display("FAIL first_flush: got flush=%b rp=%h busy=%b pv=%b expected 1/100/0/0", flush, restore_pc, busy, predict_valid); end
        tick();
        total++; if (flush !== 1'b0 || restore_pc !== 11'h100) begin bad++; $display("FAIL flush_pulse_hold: got flush=%b rp=%h expected 0/100", flush, restore_pc); end
        // counter 10 -> 11 -> stays 11: both predicted taken, no flush
        for (int n = 0; n < 2; n++) begin
            issue(11'h005, 11'h100);
            total++; if (predict_taken !== 1'b1 || next !== 11'h100) begin bad++; $display("FAIL trained_predict%0d: got pt=%b next=%h expected 1/100", n, predict_taken, next); end
            resolve(1'b1); m_update(11'h005, 1'b1);
            total++; if (flush !== 1'b0 || restore_pc !== 11'h100) begin bad++; $display("FAIL trained_noflush%0d: got flush=%b rp=%h expected 0/100", n, flush, restore_pc); end
        end
        issue(11'h005, 11'h100);
        total++; if (predict_taken !== 1'b1) begin bad++; $display("FAIL sat_high_predict: got %b expected 1", predict_taken); end
        resolve(1'b0); m_update(11'h005, 1'b0); m_rp_last = 11'h006;
        total++; if (flush !== 1'b1 || restore_pc !== 11'h006) begin bad++; $display("FAIL nt_flush: got flush=%b rp=%h expected 1/006", flush, restore_pc); end
        issue(11'h005, 11'h100);
        total++; if (predict_taken !== 1'b1) begin bad++; $display("FAIL sat_high_after_dec: got %b expected 1", predict_taken); end
        resolve(1'b1); m_update(11'h005, 1'b1);
    endtask

    task automatic test_wrap_and_floor();
        issue(11'h7FF, 11'h2AB);
        total++; if (predict_taken !== 1'b0 || next !== 11'h000) begin bad++; $display("FAIL wrap_next: got pt=%b next=%h expected 0/000", predict_taken, next); end
        resolve(1'b0); m_update(11'h7FF, 1'b0);
        issue(11'h7FF, 11'h2AB); resolve(1'b0); m_update(11'h7FF, 1'b0);
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL floor_noflush: got %b expected 0", flush); end
        issue(11'h7FF, 11'h2AB); resolve(1'b1); m_update(11'h7FF, 1'b1); m_rp_last = 11'h2AB;
        total++; if (flush !== 1'b1 || restore_pc !== 11'h2AB) begin bad++; $display("FAIL floor_taken_flush: got flush=%b rp=%h expected 1/2AB", flush, restore_pc); end
        issue(11'h7FF, 11'h2AB);
        total++; if (predict_taken !== m_dir(11'h7FF) || predict_taken !== 1'b0) begin bad++; $display("FAIL sat_low_predict: got %b expected 0", predict_taken); end
        resolve(1'b0); m_update(11'h7FF, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic exp_dir;
        issue(11'h020, 11'h040);
        total++; if (predict_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL b2b_first: got pv=%b busy=%b expected 1/1", predict_valid, busy); end
        enable = 1'b1; PC = 11'h030; I = {11'h0, 11'h050};
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_stall: got %b expected 1", stall); end
        tick(); resolve_valid = 1'b0; m_update(11'h020, 1'b0);
        total++; if ({busy, stall, flush, predict_valid} !== 4'b0000) begin bad++; $display("FAIL b2b_idle: got busy=%b stall=%b flush=%b pv=%b expected 0000", busy, stall, flush, predict_valid); end
        exp_dir = m_dir(11'h030);
        tick(); enable = 1'b0;
        total++; if ({predict_valid, predict_taken, next, busy} !== {1'b1, exp_dir, exp_dir ? 11'h050 : 11'h031, 1'b1}) begin bad++; $display("FAIL b2b_accept: got pv=%b pt=%b next=%h busy=%b expected 1/%b/%h/1", predict_valid, predict_taken, next, busy, exp_dir, exp_dir ? 11'h050 : 11'h031); end
        resolve(exp_dir); m_update(11'h030, exp_dir);
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL b2b_resolve: got flush=%b expected 0", flush); end
    endtask

    task automatic test_reset_pending();
        for (int n = 0; n < 2; n++) begin
            issue(11'h009, 11'h1AA); resolve(1'b1); m_update(11'h009, 1'b1);
        end
        issue(11'h009, 11'h1AA);
        total++; if (predict_taken !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rp_trained: got pt=%b busy=%b expected 1/1", predict_taken, busy); end
        enable = 1'b1;
        #1 reset = 1'b1;
        #1;
        total++; if ({busy, stall, flush, predict_valid, next, restore_pc} !== {4'b0000, 11'h000, 11'h000}) begin bad++; $display("FAIL rp_async: got busy=%b stall=%b flush=%b pv=%b next=%h rp=%h expected all 0", busy, stall, flush, predict_valid, next, restore_pc); end
        tick();
        enable = 1'b0;
        reset = 1'b0;
        m_reset();
        resolve(1'b1);
        total++; if (flush !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rp_idle_resolve: got flush=%b busy=%b expected 0/0", flush, busy); end
        issue(11'h009, 11'h1AA);
        total++; if (predict_taken !== 1'b0 || next !== 11'h00A) begin bad++; $display("FAIL rp_counter_init: got pt=%b next=%h expected 0/00A", predict_taken, next); end
        resolve(1'b0); m_update(11'h009, 1'b0);
    endtask

    task automatic test_random();
        logic [10:0] pc, tgt, fall, exp_next, exp_rp;
        logic        dir, tk, exp_flush, en;
        int          waits;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                resolve(1'($urandom));
                total++; if (flush !== 1'b0 || busy !== 1'b0 || restore_pc !== m_rp_last) begin bad++; $display("FAIL rnd_idle_resolve%0d: got flush=%b busy=%b rp=%h expected 0/0/%h", it, flush, busy, restore_pc, m_rp_last); end
            end
            pc  = 11'($urandom);
            tgt = 11'($urandom);
            fall = (pc == 11'd2047) ? 11'd0 : pc + 11'd1;
            dir = m_dir(pc);
            exp_next = dir ? tgt : fall;
            issue(pc, tgt);
            total++; if ({predict_valid, predict_taken, next, busy} !== {1'b1, dir, exp_next, 1'b1}) begin bad++; $display("FAIL rnd_predict%0d: got pv=%b pt=%b next=%h busy=%b expected 1/%b/%h/1", it, predict_valid, predict_taken, next, busy, dir, exp_next); end
            waits = $urandom_range(0, 3);
            for (int w = 0; w < waits; w++) begin
                en = 1'($urandom);
                enable = en; PC = 11'($urandom); I = 22'($urandom);
                #1;
                total++; if (stall !== en) begin bad++; $display("FAIL rnd_stall%0d: got %b expected %b", it, stall, en); end
                tick();
                total++; if ({predict_valid, busy, flush, next} !== {1'b0, 1'b1, 1'b0, exp_next}) begin bad++; $display("FAIL rnd_pending%0d: got pv=%b busy=%b flush=%b next=%h expected 0/1/0/%h", it, predict_valid, busy, flush, next, exp_next); end
            end
            enable = 1'b0;
            tk = 1'($urandom);
            exp_flush = (tk != dir);
            exp_rp = exp_flush ? (tk ? tgt : fall) : m_rp_last;
            resolve(tk);
            m_update(pc, tk);
            m_rp_last = exp_rp;
            total++; if ({flush, restore_pc, busy, predict_valid, next} !== {exp_flush, exp_rp, 1'b0, 1'b0, exp_next}) begin bad++; $display("FAIL rnd_resolve%0d: got flush=%b rp=%h busy=%b pv=%b next=%h expected %b/%h/0/0/%h", it, flush, restore_pc, busy, predict_valid, next, exp_flush, exp_rp, exp_next); end
        end
    endtask

    initial begin
        test_reset();
        test_counter_training();
        test_wrap_and_floor();
        test_back_to_back();
        test_reset_pending();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
